block_mem_responder: RTL and testbench

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

---
 rtl/block_mem_responder.sv | 79 +++++++
 tb/tb_block_mem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/block_mem_responder.sv
// block_mem_responder: fixed-latency 128-bit block memory target for a cache initiator
module block_mem_responder #(
    parameter int LATENCY  = 8,
    parameter int IDX_BITS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:4]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;
    state_t state, next_state;
    logic [7:0] cnt, cnt_next;
    logic wr_q;
    logic [IDX_BITS-1:0] idx_q, op_idx;
    logic [127:0] wdata_q, op_wdata;
    logic [127:0] mem [2**IDX_BITS];
    logic req, capture, fire, op_wr, err_set;
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:IDX_BITS+4];
    // With LATENCY=1 the response edge is the capture edge, so live inputs stand in for the captured ones
    always_comb begin
        req        = mem_read | mem_write;
        capture    = (state == IDLE) && req;
        op_wr      = capture ? mem_write : wr_q;
        op_idx     = capture ? mem_addr[IDX_BITS+3:4] : idx_q;
        op_wdata   = capture ? mem_wdata : wdata_q;
        err_set    = (capture && mem_read && mem_write) || (state == BUSY && !req);
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (req) begin
                cnt_next   = 8'(LATENCY - 1);
                next_state = (LATENCY == 1) ? RESP : BUSY;
            end
            BUSY: begin
                cnt_next   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                next_state = (cnt <= 8'd1) ? RESP : BUSY;
            end
            RESP: next_state = GAP;
            GAP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        fire = (next_state == RESP) && (state != RESP);
    end
    // State, counter, captured request and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            mem_ready <= fire;
            proto_err <= proto_err | err_set;
            if (capture) begin
                wr_q    <= mem_write;
                idx_q   <= mem_addr[IDX_BITS+3:4];
                wdata_q <= mem_wdata;
            end
            if (fire && !op_wr) mem_rdata <= mem[op_idx];
        end
    end
    // Array write on the response edge; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && fire && op_wr) mem[op_idx] <= op_wdata;
    end
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: table, directed and random checks against a behavioural memory model
module tb_block_mem_responder;
    logic clk = 1'b0, rst_n = 1'b0, mem_read = 1'b0, mem_write = 1'b0, sel = 1'b0;
    logic [31:4] mem_addr = '0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] rdata8, rdata1, rdata;
    logic rdy8, rdy1, err8, err1, rdy, err;
    logic rd8, wr8, rd1, wr1;
    int tests = 0, fails = 0;
    logic [127:0] ref_mem [1024];
    logic [127:0] ref_rd;
    logic ref_err;
    typedef struct {
        logic rd, wr;
        logic [31:4] addr;
        logic [127:0] wdata, exp_rdata;
        logic exp_err;
    } vec_t;
    vec_t tbl [8];
    assign rd8 = mem_read & ~sel;
    assign wr8 = mem_write & ~sel;
    assign rd1 = mem_read & sel;
    assign wr1 = mem_write & sel;
    assign rdy = sel ? rdy1 : rdy8;
    assign err = sel ? err1 : err8;
    assign rdata = sel ? rdata1 : rdata8;
    block_mem_responder #(.LATENCY(8), .IDX_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd8), .mem_write(wr8), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(rdata8), .mem_ready(rdy8), .proto_err(err8));
    block_mem_responder #(.LATENCY(1), .IDX_BITS(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_ready(rdy1), .proto_err(err1));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Memory semantics: writes update the entry, reads return it, rdata holds the last read response
    task automatic model(input logic rd, input logic wr, input logic [31:4] a, input logic [127:0] d);
        if (wr) ref_mem[a[13:4]] = d;
        else if (rd) ref_rd = ref_mem[a[13:4]];
        if (rd && wr) ref_err = 1'b1;
    endtask
    // Called at a negedge with the DUT idle; lat is the cycle (1 = just after capture) in which ready is seen
    task automatic run_op(input logic rd, input logic wr, input logic [31:4] a, input logic [127:0] d,
                          input logic late, output int lat, output logic [127:0] rd_out);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d; lat = 0;
        @(posedge clk);
        for (int n = 1; n <= 300 && lat == 0; n++) begin
            @(negedge clk);
            if (rdy) lat = n;
        end
        rd_out = rdata;
        if (late) @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        if (!late) @(negedge clk);
        @(negedge clk);
    endtask
    initial begin
        int lat, pulses;
        logic [127:0] got, v;
        logic [31:4] a;
        logic rd, wr;
        tbl[0] = '{0, 1, 28'h10,  {16{8'hA5}}, 128'h0,       0};
        tbl[1] = '{1, 0, 28'h10,  128'h0,      {16{8'hA5}}, 0};
        tbl[2] = '{0, 1, 28'h400, 128'h1,      {16{8'hA5}}, 0};
        tbl[3] = '{0, 1, 28'h0,   128'h2,      {16{8'hA5}}, 0};
        tbl[4] = '{1, 0, 28'h400, 128'h0,      128'h2,       0};
        tbl[5] = '{1, 1, 28'h20,  128'h77,     128'h2,       1};
        tbl[6] = '{1, 0, 28'h20,  128'h0,      128'h77,      1};
        tbl[7] = '{1, 0, 28'h0,   128'h0,      128'h2,       1};
        for (int i = 0; i < 1024; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            dut.mem[i] <= v;
            ref_mem[i] = v;
        end
        ref_rd = '0; ref_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {127'b0, rdy8}, 128'h0);
        chk("reset_rdata", rdata8, 128'h0);
        chk("reset_err", {127'b0, err8}, 128'h0);
        chk("reset_ready_l1", {127'b0, rdy1}, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, lat, got);
            model(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("tbl%0d_lat", i), 128'(lat), 128'd8);
            chk($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), {127'b0, err}, {127'b0, tbl[i].exp_err});
        end
        mem_write = 1'b1; mem_addr = 28'h5; mem_wdata = {128{1'b1}};
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0; mem_write = 1'b0;
        #1;
        chk("midrst_ready", {127'b0, rdy}, 128'h0);
        chk("midrst_rdata", rdata, 128'h0);
        chk("midrst_err", {127'b0, err}, 128'h0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (rdy || rdata != 0) pulses++;
        end
        chk("midrst_held", 128'(pulses), 128'd0);
        rst_n = 1'b1; ref_rd = '0; ref_err = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        chk("midrst_no_pulse", 128'(pulses), 128'd0);
        run_op(1'b1, 1'b0, 28'h5, 128'h0, 1'b0, lat, got);
        model(1'b1, 1'b0, 28'h5, 128'h0);
        chk("midrst_read_lat", 128'(lat), 128'd8);
        chk("midrst_read_data", got, ref_rd);
        run_op(1'b1, 1'b0, 28'h10, 128'h0, 1'b1, lat, got);
        model(1'b1, 1'b0, 28'h10, 128'h0);
        chk("late_lat", 128'(lat), 128'd8);
        chk("late_data", got, {16{8'hA5}});
        run_op(1'b1, 1'b0, 28'h400, 128'h0, 1'b0, lat, got);
        model(1'b1, 1'b0, 28'h400, 128'h0);
        chk("after_gap_lat", 128'(lat), 128'd8);
        chk("after_gap_data", got, 128'h2);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        chk("late_no_second", 128'(pulses), 128'd0);
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            rd = (r == 0) || (r >= 4);
            wr = (r <= 3);
            a = 28'($urandom);
            v = {$urandom, $urandom, $urandom, $urandom};
            run_op(rd, wr, a, v, 1'b0, lat, got);
            model(rd, wr, a, v);
            chk($sformatf("rnd%0d_lat", i), 128'(lat), 128'd8);
            chk($sformatf("rnd%0d_rdata", i), got, ref_rd);
            chk($sformatf("rnd%0d_err", i), {127'b0, err}, {127'b0, ref_err});
        end
        sel = 1'b1;
        @(negedge clk);
        v = {4{32'hC0DE_1234}};
        run_op(1'b0, 1'b1, 28'h33, v, 1'b0, lat, got);
        chk("l1_write_lat", 128'(lat), 128'd1);
        run_op(1'b1, 1'b0, 28'h33, 128'h0, 1'b0, lat, got);
        chk("l1_read_lat", 128'(lat), 128'd1);
        chk("l1_read_data", got, v);
        run_op(1'b1, 1'b0, 28'h433, 128'h0, 1'b0, lat, got);
        chk("l1_alias_lat", 128'(lat), 128'd1);
        chk("l1_alias_data", got, v);
        chk("l1_err", {127'b0, err}, 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
